// File: rtl/frame_sym_scheduler.sv
// frame_sym_scheduler: per-frame walk of the symbol program buffer into staging, atomic commit to render shadows.
// Revision 1.0 - initial release
`default_nettype none

module frame_sym_scheduler #(
  parameter int PROG_BITS = 48,
  parameter int NUM_SYM   = 2,
  parameter int IDX_W     = 1
) (
  input  logic                         i_clk,
  input  logic                         rst,
  input  logic                         n_vsync,
  input  logic                         is_sym_mode,
  input  logic                         buf_we,
  input  logic [NUM_SYM-1:0]           valid_idx,
  input  logic [PROG_BITS-1:0]         rdata,
  output logic                         re,
  output logic [IDX_W-1:0]             raddr,
  output logic [NUM_SYM*PROG_BITS-1:0] sym_attr,
  output logic [NUM_SYM-1:0]           sym_valid,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

  state_t                       state;
  state_t                       state_nxt;
  logic [IDX_W-1:0]             idx;
  logic                         n_vsync_q;
  logic                         vsync_start;
  logic                         is_last;
  logic                         start_walk;
  logic                         skip_id;
  logic                         capture_id;
  logic                         advance;
  logic [PROG_BITS-1:0]         stage [NUM_SYM];
  logic [NUM_SYM-1:0]           stage_valid;
  logic [NUM_SYM*PROG_BITS-1:0] stage_flat;

  assign vsync_start = n_vsync_q & ~n_vsync;
  assign is_last     = (idx == LAST_IDX);
  assign raddr       = idx;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == COMMIT);

  generate
    for (genvar g = 0; g < NUM_SYM; g++) begin : g_pack
      assign stage_flat[g*PROG_BITS +: PROG_BITS] = stage[g];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Mode drop aborts from ISSUE or CAPTURE; a pending write only stalls a real read.
  always_comb begin
    state_nxt  = state;
    start_walk = 1'b0;
    skip_id    = 1'b0;
    capture_id = 1'b0;
    advance    = 1'b0;
    re         = 1'b0;
    case (state)
      IDLE: begin
        if (vsync_start && is_sym_mode) begin
          start_walk = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!is_sym_mode) begin
          state_nxt = IDLE;
        end else if (!valid_idx[idx]) begin
          skip_id   = 1'b1;
          advance   = 1'b1;
          state_nxt = is_last ? COMMIT : ISSUE;
        end else if (!buf_we) begin
          re        = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!is_sym_mode) begin
          state_nxt = IDLE;
        end else begin
          capture_id = 1'b1;
          advance    = 1'b1;
          state_nxt  = is_last ? COMMIT : ISSUE;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      n_vsync_q   <= 1'b1;
      idx         <= '0;
      overrun     <= 1'b0;
      stage_valid <= '0;
      sym_attr    <= '0;
      sym_valid   <= '0;
      for (int k = 0; k < NUM_SYM; k++) stage[k] <= '0;
    end else begin
      n_vsync_q <= n_vsync;
      if (vsync_start && (state != IDLE)) overrun <= 1'b1;
      if (start_walk) begin
        idx         <= '0;
        stage_valid <= '0;
        for (int k = 0; k < NUM_SYM; k++) stage[k] <= '0;
      end else if (advance && !is_last) begin
        idx <= idx + 1'b1;
      end
      if (skip_id) begin
        stage_valid[idx] <= 1'b0;
        stage[idx]       <= '0;
      end
      if (capture_id) begin
        stage_valid[idx] <= 1'b1;
        stage[idx]       <= rdata;
      end
      if (state == COMMIT) begin
        sym_attr  <= stage_flat;
        sym_valid <= stage_valid;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_sym_scheduler.sv
// tb_frame_sym_scheduler: directed frames checked cycle-by-cycle against a queue-based walk model.
`default_nettype none

module tb_frame_sym_scheduler;
  localparam int PB = 48;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          n_vsync = 1'b1;
  logic          is_sym_mode = 1'b1;
  logic          buf_we = 1'b0;
  logic [NS-1:0] valid_idx = 2'b11;
  logic [PB-1:0] rdata = '0;
  logic          re;
  logic [0:0]    raddr;
  logic [NS*PB-1:0] sym_attr;
  logic [NS-1:0] sym_valid;
  logic          busy, frame_done, overrun;

  logic [PB-1:0] mem [NS];

  int n_checks = 0;
  int n_fail = 0;

  frame_sym_scheduler #(.PROG_BITS(PB), .NUM_SYM(NS), .IDX_W(1)) dut (
    .i_clk(clk), .rst(rst), .n_vsync(n_vsync), .is_sym_mode(is_sym_mode),
    .buf_we(buf_we), .valid_idx(valid_idx), .rdata(rdata), .re(re), .raddr(raddr),
    .sym_attr(sym_attr), .sym_valid(sym_valid), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency.
  always @(posedge clk) if (re) rdata <= mem[raddr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walk model: a queue of IDs still to visit, one outstanding read, a pending commit.
  logic [PB-1:0]    m_stage [NS] = '{default: '0};
  logic [NS-1:0]    m_stv = '0;
  logic [NS*PB-1:0] m_attr = '0;
  logic [NS-1:0]    m_valid = '0;
  bit m_over = 0, m_walk = 0, m_out = 0, m_commit = 0, m_prev_nv = 1;
  int m_q[$];
  int m_id = 0;
  bit vs, e_re, e_fd, e_busy, e_over;
  int e_addr;
  logic [NS*PB-1:0] e_attr;
  logic [NS-1:0]    e_val;

  always @(negedge clk) begin
    vs     = m_prev_nv && !n_vsync;
    e_re   = 0;
    e_addr = 0;
    e_fd   = m_commit;
    e_busy = m_walk;
    e_over = m_over;
    e_attr = m_attr;
    e_val  = m_valid;
    if (rst) begin
      m_walk = 0; m_out = 0; m_commit = 0; m_over = 0;
      m_attr = '0; m_valid = '0; m_stv = '0; m_q.delete();
      for (int k = 0; k < NS; k++) m_stage[k] = '0;
    end else begin
      if (vs && m_walk) m_over = 1;
      if (m_commit) begin
        m_attr   = {m_stage[1], m_stage[0]};
        m_valid  = m_stv;
        m_commit = 0;
        m_walk   = 0;
      end else if (m_walk) begin
        if (!is_sym_mode) begin
          m_walk = 0; m_out = 0; m_q.delete();
        end else if (m_out) begin
          m_stage[m_id] = mem[m_id];
          m_stv[m_id]   = 1'b1;
          m_out         = 0;
          if (m_q.size() == 0) m_commit = 1;
        end else begin
          m_id = m_q[0];
          if (!valid_idx[m_id]) begin
            m_stage[m_id] = '0;
            m_stv[m_id]   = 1'b0;
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_commit = 1;
          end else if (!buf_we) begin
            e_re   = 1;
            e_addr = m_id;
            void'(m_q.pop_front());
            m_out  = 1;
          end
        end
      end else if (vs && is_sym_mode) begin
        m_walk = 1;
        m_q.delete();
        for (int k = 0; k < NS; k++) begin
          m_q.push_back(k);
          m_stage[k] = '0;
        end
        m_stv = '0;
      end
    end
    m_prev_nv = rst ? 1'b1 : n_vsync;

    chk("re", 128'(re), 128'(e_re));
    if (e_re) chk("raddr", 128'(raddr), 128'(e_addr));
    chk("frame_done", 128'(frame_done), 128'(e_fd));
    chk("busy", 128'(busy), 128'(e_busy));
    chk("overrun", 128'(overrun), 128'(e_over));
    chk("sym_attr", 128'(sym_attr), 128'(e_attr));
    chk("sym_valid", 128'(sym_valid), 128'(e_val));
  end

  // One frame: vsync falls in cycle 0; per-cycle hooks for writes, mode drop, second vsync, reset.
  task automatic run_frame(input int we_from, input int we_len, input int drop_at,
                           input int vs2_at, input int rst_at, output int lat, output int ndone);
    lat = -1;
    ndone = 0;
    n_vsync = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      n_vsync = (c == vs2_at) ? 1'b0 : 1'b1;
      buf_we  = (c >= we_from) && (c < we_from + we_len);
      if (c == drop_at) is_sym_mode = 1'b0;
      rst = (c == rst_at);
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_re", 128'(re), 128'(0));
        chk("rst_raddr", 128'(raddr), 128'(0));
        chk("rst_attr", 128'(sym_attr), 128'(0));
        chk("rst_valid", 128'(sym_valid), 128'(0));
        chk("rst_overrun", 128'(overrun), 128'(0));
      end
      if (frame_done === 1'b1) begin
        if (lat < 0) lat = c;
        ndone++;
      end
    end
    is_sym_mode = 1'b1;
    buf_we = 1'b0;
  endtask

  int lat, nd;

  initial begin
    mem[0] = 48'hA;
    mem[1] = 48'hB;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_attr", 128'(sym_attr), 128'(0));
    chk("reset_overrun", 128'(overrun), 128'(0));
    repeat (2) @(posedge clk);
    #1;

    run_frame(0, 0, 0, 0, 0, lat, nd);
    chk("both_lat", 128'(lat), 128'(5));
    chk("both_attr", 128'(sym_attr), 128'({48'hB, 48'hA}));
    chk("both_valid", 128'(sym_valid), 128'(2'b11));

    valid_idx = 2'b10;
    run_frame(0, 0, 0, 0, 0, lat, nd);
    chk("one_lat", 128'(lat), 128'(4));
    chk("one_valid", 128'(sym_valid), 128'(2'b10));
    chk("one_attr", 128'(sym_attr), 128'({48'hB, 48'h0}));

    valid_idx = 2'b11;
    mem[0] = 48'hC;
    mem[1] = 48'hD;
    run_frame(1, 3, 0, 0, 0, lat, nd);
    chk("stall_lat", 128'(lat), 128'(8));
    chk("stall_attr", 128'(sym_attr), 128'({48'hD, 48'hC}));

    mem[0] = 48'hA;
    mem[1] = 48'hB;
    run_frame(0, 0, 0, 0, 0, lat, nd);
    chk("pre_abort_attr", 128'(sym_attr), 128'({48'hB, 48'hA}));
    mem[0] = 48'hE;
    mem[1] = 48'hF;
    run_frame(0, 0, 2, 0, 0, lat, nd);
    chk("abort_no_done", 128'(nd), 128'(0));
    chk("abort_attr", 128'(sym_attr), 128'({48'hB, 48'hA}));

    run_frame(1, 6, 0, 3, 0, lat, nd);
    chk("ovr_lat", 128'(lat), 128'(11));
    chk("ovr_ndone", 128'(nd), 128'(1));
    chk("ovr_sticky", 128'(overrun), 128'(1));
    chk("ovr_attr", 128'(sym_attr), 128'({48'hF, 48'hE}));

    mem[0] = 48'h1234;
    mem[1] = 48'h5678;
    run_frame(0, 0, 0, 0, 4, lat, nd);
    chk("rst_walk_no_done", 128'(nd), 128'(0));

    run_frame(0, 0, 0, 0, 0, lat, nd);
    chk("clean_lat", 128'(lat), 128'(5));
    chk("clean_attr", 128'(sym_attr), 128'({48'h5678, 48'h1234}));
    chk("clean_overrun", 128'(overrun), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
